uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares the single 32-bit UART word transmitter (uart_buf_tx) between N_REQ game-logic producers,
//  e.g. paddle position, ball state and score. Each producer drops a word into a private holding
//  slot; the scheduler grants slots round-robin, holds start until the transmitter accepts, waits
//  for completion, then enforces an inter-word gap. Sits between game logic and uart_buf_tx.
// PARAMETERS
//  N_REQ       4    number of requesters (>=2)
//  DATA_W      32   word width; must match the transmitter tbuf width
//  GAP_CYCLES  16   idle clk cycles forced after each completed word (0 = no gap)
// PORTS
//  clk        in   1                clock
//  rst        in   1                synchronous, active-high reset
//  req        in   N_REQ            per-channel 1-cycle write strobe
//  req_data   in   N_REQ*DATA_W     per-channel word, channel i at [i*DATA_W +: DATA_W]
//  pending    out  N_REQ            slot i holds an unsent word
//  overwrite  out  N_REQ            1-cycle pulse: req hit an already-pending slot
//  buf_ready  in   1                transmitter idle (uart_buf_tx ready)
//  buf_start  out  1                start request to transmitter, level-held
//  buf_data   out  DATA_W           word to transmitter (tbuf), stable while busy
//  grant_id   out  $clog2(N_REQ)    channel currently being sent
//  busy       out  1                scheduler not in IDLE
// BEHAVIOUR
//  Reset: pending=0, overwrite=0, buf_start=0, buf_data=0, grant_id=0, busy=0, rr pointer=0, FSM=IDLE.
//  Reset mid-transfer drops all pending words and deasserts buf_start the next cycle.
//  Slots: req[i]=1 latches req_data[i] into slot i and sets pending[i] (latest value wins).
//   If pending[i] was already 1, overwrite[i] pulses for one cycle.
//  Arbitration: round-robin starting from the channel after the last grant; lowest index wins
//   among ties at the pointer origin. After a grant, the pointer is set to grant_id+1 (mod N_REQ).
//  FSM (all transitions registered):
//   IDLE : if any pending, choose ch. Copy slot->buf_data, grant_id=ch, clear pending[ch]. -> ISSUE
//   ISSUE: buf_start=1, held until buf_ready==0 observed, then buf_start=0. -> XFER
//   XFER : wait buf_ready==1. -> GAP (or IDLE if GAP_CYCLES==0)
//   GAP  : count GAP_CYCLES cycles, then -> IDLE
//  Latency: req to buf_start=1 is 2 cycles when IDLE (slot write, then grant/ISSUE).
//  Same-cycle req[ch] and grant of ch: buf_data takes the OLD slot value. The slot takes the new value;
//   pending[ch] stays 1 and overwrite does not pulse.
//  buf_data and grant_id change only in the IDLE->ISSUE transition.
//  Transmitter refusing start (tready low) is tolerated: buf_start is held indefinitely in ISSUE.
//  Gap counter is $clog2(GAP_CYCLES+1) bits wide; it does not wrap.
//  No request is ever lost silently: either it is sent, or overwrite flags its replacement.
// STRUCTURE
//  Package pong_uart_pkg holds:
//   - sched_state_t enum {IDLE, ISSUE, XFER, GAP}
//   - UART_WORD_W = 32
//  Sub-module rr_arbiter #(N) does the combinational round-robin pick:
//   inputs req_vec and ptr; outputs gnt_valid and gnt_idx.
//  Slot registers, FSM and gap counter live in this module.
// TESTING
//  1. Single req on ch2 with data 0xDEADBEEF, buf_ready model idle:
//     buf_start rises 2 cycles later, buf_data=0xDEADBEEF, grant_id=2, pending[2] clears.
//  2. req on ch0..3 in the same cycle: grants go 0,1,2,3. Then req on ch0 and ch3 together:
//     next grant is 0 (pointer has wrapped to 0).
//  3. Two reqs on ch1 (0x11, then 0x22) while the scheduler sends ch0:
//     overwrite[1] pulses once and 0x22 is sent; 0x11 is never sent.
//  4. Transmitter model holds buf_ready=1 and ignores start for 50 cycles:
//     buf_start stays 1 and buf_data stays stable until the model accepts.
//  5. GAP_CYCLES=16 with back-to-back pending words: exactly 16 idle cycles between buf_ready rising
//     and the next IDLE->ISSUE.
//  6. rst asserted in XFER with 3 words pending:
//     all outputs hit reset values next cycle, and no buf_start occurs after rst falls.

Source files
------------

// File: rtl/pong_uart_pkg.sv
// Shared types and constants for the pong UART transmit path.
package pong_uart_pkg;

    localparam int unsigned UART_WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER,
        GAP
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: scans req_vec starting at ptr, first hit wins.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_vec,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = IW'((32'(ptr) + off) % N);
            if (!gnt_valid && req_vec[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART word transmitter between N_REQ producers,
// with per-channel holding slots, start/accept handshake and a post-word idle gap.
module uart_tx_scheduler
    import pong_uart_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_W     = UART_WORD_W,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          pending,
    output logic [N_REQ-1:0]          overwrite,
    input  logic                      buf_ready,
    output logic                      buf_start,
    output logic [DATA_W-1:0]         buf_data,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      busy
);

    localparam int unsigned IW    = $clog2(N_REQ);
    localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    sched_state_t      state_q, state_d;
    logic [DATA_W-1:0] slot_q [N_REQ];
    logic [IW-1:0]     ptr_q;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic              gnt_valid;
    logic [IW-1:0]     gnt_idx;
    logic              grant_fire;
    logic [N_REQ-1:0]  grant_clr;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req_vec   (pending),
        .ptr       (ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        grant_fire = (state_q == IDLE) && gnt_valid;
        grant_clr  = '0;
        if (grant_fire) begin
            grant_clr[gnt_idx] = 1'b1;
        end
    end

    // A write landing on the slot being granted refills it rather than replacing
    // an unsent word, so it stays pending and is not reported as an overwrite.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            overwrite <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                overwrite[i] <= req[i] & pending[i] & ~grant_clr[i];
                if (req[i]) begin
                    slot_q[i]  <= req_data[i*DATA_W +: DATA_W];
                    pending[i] <= 1'b1;
                end else if (grant_clr[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_data <= '0;
            grant_id <= '0;
            ptr_q    <= '0;
        end else if (grant_fire) begin
            buf_data <= slot_q[gnt_idx];
            grant_id <= gnt_idx;
            ptr_q    <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state_q != GAP) begin
            gap_cnt_q <= '0;
        end else if (gap_cnt_q != GAP_LAST) begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (gnt_valid)             state_d = ISSUE;
            ISSUE: if (!buf_ready)            state_d = XFER;
            XFER:  if (buf_ready)             state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:   if (gap_cnt_q == GAP_LAST) state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_comb begin
        buf_start = (state_q == ISSUE);
        busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler with a behavioural transmitter model.
module tb_uart_tx_scheduler;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned GAPC  = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_REQ-1:0]      req;
    logic [N_REQ*DW-1:0]   req_data;
    logic [N_REQ-1:0]      pending;
    logic [N_REQ-1:0]      overwrite;
    logic                  buf_ready;
    logic                  buf_start;
    logic [DW-1:0]         buf_data;
    logic [1:0]            grant_id;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    int unsigned accept_delay = 0;
    int unsigned xfer_len     = 3;
    int unsigned m_wait       = 0;
    int unsigned m_busy       = 0;
    logic [1:0]  sent_id   [$];
    logic [31:0] sent_data [$];

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .N_REQ      (N_REQ),
        .DATA_W     (DW),
        .GAP_CYCLES (GAPC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .pending   (pending),
        .overwrite (overwrite),
        .buf_ready (buf_ready),
        .buf_start (buf_start),
        .buf_data  (buf_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    // Transmitter model: ignores start for accept_delay cycles, then is busy for xfer_len.
    always @(negedge clk) begin
        if (rst) begin
            buf_ready = 1'b1;
            m_wait    = 0;
            m_busy    = 0;
        end else if (m_busy != 0) begin
            m_busy = m_busy - 1;
            if (m_busy == 0) buf_ready = 1'b1;
        end else if (buf_start && buf_ready) begin
            if (m_wait < accept_delay) begin
                m_wait = m_wait + 1;
            end else begin
                m_wait    = 0;
                buf_ready = 1'b0;
                m_busy    = xfer_len;
                sent_id.push_back(grant_id);
                sent_data.push_back(buf_data);
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_done(input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int unsigned k = 0; k < budget; k++) begin
            if (!busy && pending == '0) ok = 1'b1;
            if (ok) break;
            tick(1);
        end
    endtask

    task automatic wait_ready(input logic lvl, input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int unsigned k = 0; k < budget; k++) begin
            if (buf_ready === lvl) ok = 1'b1;
            if (ok) break;
            tick(1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = '1;
        req_data = '1;
        tick(2);
        checks++; if (pending !== 4'b0000)   begin errors++; $display("FAIL reset_pending: got %b expected 0000", pending); end
        checks++; if (overwrite !== 4'b0000) begin errors++; $display("FAIL reset_overwrite: got %b expected 0000", overwrite); end
        checks++; if (buf_start !== 1'b0)    begin errors++; $display("FAIL reset_buf_start: got %b expected 0", buf_start); end
        checks++; if (buf_data !== 32'h0)    begin errors++; $display("FAIL reset_buf_data: got %h expected 00000000", buf_data); end
        checks++; if (grant_id !== 2'd0)     begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        req = '0;
        req_data = '0;
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_single_req;
        int unsigned b;
        bit ok;
        do_reset;
        b = sent_id.size();
        req_data[2*DW +: DW] = 32'hDEADBEEF;
        req = 4'b0100;
        tick(1);
        req = '0;
        checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL single_pending_set: got %b expected 0100", pending); end
        checks++; if (buf_start !== 1'b0)  begin errors++; $display("FAIL single_start_early: got %b expected 0", buf_start); end
        tick(1);
        checks++; if (buf_start !== 1'b1)        begin errors++; $display("FAIL single_start: got %b expected 1", buf_start); end
        checks++; if (buf_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h expected deadbeef", buf_data); end
        checks++; if (grant_id !== 2'd2)         begin errors++; $display("FAIL single_grant: got %0d expected 2", grant_id); end
        checks++; if (pending !== 4'b0000)       begin errors++; $display("FAIL single_pending_clr: got %b expected 0000", pending); end
        wait_done(500, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_timeout: got %b expected 1", ok); end
        checks++; if (sent_id.size() !== b + 1) begin errors++; $display("FAIL single_count: got %0d expected %0d", sent_id.size(), b + 1); end
        else begin
            checks++; if (sent_data[b] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_sent: got %h expected deadbeef", sent_data[b]); end
        end
    endtask

    task automatic test_round_robin;
        int unsigned b;
        bit ok;
        logic [1:0]  exp_id   [6];
        logic [31:0] exp_data [6];
        exp_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
        exp_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hB0, 32'hB3};
        do_reset;
        b = sent_id.size();
        for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = 32'hA0 + 32'(i);
        req = 4'b1111;
        tick(1);
        req = '0;
        wait_done(1000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rr_timeout1: got %b expected 1", ok); end
        req_data[0*DW +: DW] = 32'hB0;
        req_data[3*DW +: DW] = 32'hB3;
        req = 4'b1001;
        tick(1);
        req = '0;
        wait_done(1000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rr_timeout2: got %b expected 1", ok); end
        checks++; if (sent_id.size() !== b + 6) begin errors++; $display("FAIL rr_count: got %0d expected %0d", sent_id.size(), b + 6); end
        else begin
            for (int k = 0; k < 6; k++) begin
                checks++; if (sent_id[b+k] !== exp_id[k])     begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, sent_id[b+k], exp_id[k]); end
                checks++; if (sent_data[b+k] !== exp_data[k]) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", k, sent_data[b+k], exp_data[k]); end
            end
        end
    endtask

    task automatic test_overwrite;
        int unsigned b;
        bit ok;
        do_reset;
        b = sent_id.size();
        req_data[0*DW +: DW] = 32'h100;
        req = 4'b0001;
        tick(1);
        req = '0;
        tick(1);
        checks++; if (buf_start !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL ow_grant0: got start=%b id=%0d expected start=1 id=0", buf_start, grant_id); end
        req_data[1*DW +: DW] = 32'h11;
        req = 4'b0010;
        tick(1);
        checks++; if (overwrite !== 4'b0000) begin errors++; $display("FAIL ow_first: got %b expected 0000", overwrite); end
        checks++; if (pending !== 4'b0010)   begin errors++; $display("FAIL ow_pending: got %b expected 0010", pending); end
        req_data[1*DW +: DW] = 32'h22;
        tick(1);
        req = '0;
        checks++; if (overwrite !== 4'b0010) begin errors++; $display("FAIL ow_pulse: got %b expected 0010", overwrite); end
        tick(1);
        checks++; if (overwrite !== 4'b0000) begin errors++; $display("FAIL ow_pulse_end: got %b expected 0000", overwrite); end
        wait_done(500, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ow_timeout: got %b expected 1", ok); end
        checks++; if (sent_id.size() !== b + 2) begin errors++; $display("FAIL ow_count: got %0d expected %0d", sent_id.size(), b + 2); end
        else begin
            checks++; if (sent_id[b+1] !== 2'd1 || sent_data[b+1] !== 32'h22) begin errors++; $display("FAIL ow_sent: got id=%0d data=%h expected id=1 data=00000022", sent_id[b+1], sent_data[b+1]); end
        end
    endtask

    task automatic test_refuse;
        int unsigned b;
        bit ok;
        accept_delay = 50;
        do_reset;
        b = sent_id.size();
        req_data[1*DW +: DW] = 32'h5A5A;
        req = 4'b0010;
        tick(1);
        req = '0;
        tick(1);
        for (int i = 0; i < 51; i++) begin
            checks++; if (buf_start !== 1'b1)    begin errors++; $display("FAIL refuse_start[%0d]: got %b expected 1", i, buf_start); end
            checks++; if (buf_data !== 32'h5A5A) begin errors++; $display("FAIL refuse_data[%0d]: got %h expected 00005a5a", i, buf_data); end
            tick(1);
        end
        checks++; if (buf_start !== 1'b0) begin errors++; $display("FAIL refuse_release: got %b expected 0", buf_start); end
        wait_done(500, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL refuse_timeout: got %b expected 1", ok); end
        checks++; if (sent_id.size() !== b + 1) begin errors++; $display("FAIL refuse_count: got %0d expected %0d", sent_id.size(), b + 1); end
        else begin
            checks++; if (sent_data[b] !== 32'h5A5A) begin errors++; $display("FAIL refuse_sent: got %h expected 00005a5a", sent_data[b]); end
        end
        accept_delay = 0;
    endtask

    task automatic test_gap;
        bit ok;
        int unsigned n;
        do_reset;
        req_data[0*DW +: DW] = 32'hC0;
        req_data[1*DW +: DW] = 32'hC1;
        req = 4'b0011;
        tick(1);
        req = '0;
        tick(1);
        checks++; if (buf_start !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL gap_first: got start=%b id=%0d expected start=1 id=0", buf_start, grant_id); end
        wait_ready(1'b0, 200, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL gap_accept_timeout: got %b expected 1", ok); end
        wait_ready(1'b1, 200, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL gap_done_timeout: got %b expected 1", ok); end
        n = 0;
        while (busy && !buf_start && n < 100) begin
            n++;
            tick(1);
        end
        checks++; if (n !== GAPC) begin errors++; $display("FAIL gap_len: got %0d expected %0d", n, GAPC); end
        checks++; if (busy !== 1'b0 || buf_start !== 1'b0) begin errors++; $display("FAIL gap_idle: got busy=%b start=%b expected 0 0", busy, buf_start); end
        tick(1);
        checks++; if (buf_start !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL gap_next: got start=%b id=%0d expected start=1 id=1", buf_start, grant_id); end
        wait_done(500, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL gap_timeout: got %b expected 1", ok); end
    endtask

    task automatic test_reset_mid;
        int unsigned b;
        int unsigned starts;
        bit ok;
        xfer_len = 20;
        do_reset;
        b = sent_id.size();
        req_data[0*DW +: DW] = 32'hD0;
        req = 4'b0001;
        tick(1);
        req = '0;
        tick(1);
        wait_ready(1'b0, 200, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rmid_accept_timeout: got %b expected 1", ok); end
        for (int i = 1; i < 4; i++) req_data[i*DW +: DW] = 32'hE0 + 32'(i);
        req = 4'b1110;
        tick(1);
        req = '0;
        checks++; if (pending !== 4'b1110 || busy !== 1'b1 || buf_start !== 1'b0) begin errors++; $display("FAIL rmid_xfer: got pend=%b busy=%b start=%b expected 1110 1 0", pending, busy, buf_start); end
        rst = 1'b1;
        tick(1);
        checks++; if (pending !== 4'b0000)   begin errors++; $display("FAIL rmid_pending: got %b expected 0000", pending); end
        checks++; if (overwrite !== 4'b0000) begin errors++; $display("FAIL rmid_overwrite: got %b expected 0000", overwrite); end
        checks++; if (buf_start !== 1'b0)    begin errors++; $display("FAIL rmid_start: got %b expected 0", buf_start); end
        checks++; if (buf_data !== 32'h0)    begin errors++; $display("FAIL rmid_data: got %h expected 00000000", buf_data); end
        checks++; if (grant_id !== 2'd0)     begin errors++; $display("FAIL rmid_grant: got %0d expected 0", grant_id); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        rst = 1'b0;
        starts = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (buf_start === 1'b1) starts++;
        end
        checks++; if (starts !== 0) begin errors++; $display("FAIL rmid_no_start: got %0d starts expected 0", starts); end
        checks++; if (sent_id.size() !== b + 1) begin errors++; $display("FAIL rmid_count: got %0d expected %0d", sent_id.size(), b + 1); end
        xfer_len = 3;
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        test_reset;
        test_single_req;
        test_round_robin;
        test_overwrite;
        test_refuse;
        test_gap;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
